// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: line bursts from the system bus, split into
// instructions, buffered in a FIFO toward decode, with redirect/flush support.
module instr_fetch_queue #(
  parameter int          BUS_DATA_WIDTH = 64,
  parameter int          BUS_TAG_WIDTH  = 13,
  parameter int          INSTR_WIDTH    = 32,
  parameter int          BURST_BEATS    = 8,
  parameter int          QUEUE_DEPTH    = 16,
  parameter logic [3:0]  SYSBUS_MEMORY  = 4'h1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      out_valid,
  output logic [INSTR_WIDTH-1:0]    out_instr,
  output logic [63:0]               out_pc,
  input  logic                      out_ready
);

  localparam int IPB         = BUS_DATA_WIDTH / INSTR_WIDTH;
  localparam int BEAT_BYTES  = BUS_DATA_WIDTH / 8;
  localparam int INSTR_BYTES = INSTR_WIDTH / 8;
  localparam int LINE_BYTES  = BURST_BEATS * BEAT_BYTES;
  localparam int LINE_BITS   = $clog2(LINE_BYTES);
  localparam int BEAT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int PTR_W       = $clog2(QUEUE_DEPTH);
  localparam int CNT_W       = PTR_W + 1;
  localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG =
    BUS_TAG_WIDTH'({1'b1, SYSBUS_MEMORY, 8'h00});
  localparam logic [63:0] LINE_STEP = 64'(LINE_BYTES);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [63:0]            line_pc, line_nxt;
  logic [63:0]            start_pc, start_nxt;
  logic [63:0]            req_addr;
  logic                   redir_pend, pend_nxt;
  logic [BEAT_W-1:0]      beat_cnt, beat_nxt;
  logic [PTR_W-1:0]       rptr, wptr;
  logic [CNT_W-1:0]       count;

  logic [INSTR_WIDTH-1:0] instr_mem [QUEUE_DEPTH];
  logic [63:0]            pc_mem    [QUEUE_DEPTH];

  logic                   room, last_beat, accept, push, pop;
  logic [IPB-1:0]         slot_keep;
  logic [PTR_W-1:0]       slot_idx [IPB];
  logic [63:0]            slot_pc  [IPB];
  logic [LINE_BITS-1:0]   slot_off;
  logic [CNT_W-1:0]       n_keep, n_push;
  logic                   unused_bits;

  // Room is judged on the occupancy before any same-cycle pop.
  assign room      = (CNT_W'(QUEUE_DEPTH) - count) >= CNT_W'(IPB);
  assign last_beat = (beat_cnt == BEAT_W'(BURST_BEATS - 1));
  assign accept    = (state == RESP) && bus_respcyc && room;
  assign push      = accept && !redirect_valid;
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign n_push    = push ? n_keep : '0;

  assign out_valid  = (count != '0);
  assign out_instr  = out_valid ? instr_mem[rptr] : '0;
  assign out_pc     = out_valid ? pc_mem[rptr] : '0;
  assign bus_req    = bus_reqcyc ? BUS_DATA_WIDTH'(req_addr) : '0;
  assign bus_reqtag = bus_reqcyc ? REQ_TAG : '0;

  assign unused_bits = ^{bus_resptag, start_pc[63:LINE_BITS]};

  // Compact the kept slots of the beat onto consecutive FIFO entries.
  always_comb begin
    n_keep    = '0;
    slot_keep = '0;
    slot_off  = '0;
    for (int s = 0; s < IPB; s++) begin
      slot_off     = LINE_BITS'(beat_cnt) * LINE_BITS'(BEAT_BYTES)
                   + LINE_BITS'(s * INSTR_BYTES);
      slot_pc[s]   = {line_pc[63:LINE_BITS], slot_off};
      slot_keep[s] = (slot_off >= start_pc[LINE_BITS-1:0]);
      slot_idx[s]  = wptr + PTR_W'(n_keep);
      if (slot_keep[s])
        n_keep = n_keep + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    line_nxt    = line_pc;
    start_nxt   = start_pc;
    pend_nxt    = redir_pend;
    beat_nxt    = beat_cnt;
    bus_reqcyc  = 1'b0;
    bus_respack = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        bus_reqcyc = 1'b1;
        if (redirect_valid)
          pend_nxt = 1'b1;
        if (bus_reqack) begin
          state_nxt = (redirect_valid || redir_pend) ? DRAIN : RESP;
          pend_nxt  = 1'b0;
          beat_nxt  = '0;
        end
      end
      RESP: begin
        bus_respack = accept;
        if (accept) begin
          beat_nxt = beat_cnt + 1'b1;
          if (last_beat) begin
            beat_nxt  = '0;
            state_nxt = REQ;
            line_nxt  = line_pc + LINE_STEP;
            start_nxt = line_pc + LINE_STEP;
          end
        end
        // A redirect on the final accepted beat goes straight to the new line.
        if (redirect_valid && !(accept && last_beat))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        bus_respack = bus_respcyc;
        if (bus_respcyc) begin
          beat_nxt = beat_cnt + 1'b1;
          if (last_beat) begin
            beat_nxt  = '0;
            state_nxt = REQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) begin
      line_nxt  = {redirect_pc[63:LINE_BITS], LINE_BITS'(0)};
      start_nxt = redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      line_pc    <= {entry[63:LINE_BITS], LINE_BITS'(0)};
      start_pc   <= entry;
      req_addr   <= {entry[63:LINE_BITS], LINE_BITS'(0)};
      redir_pend <= 1'b0;
      beat_cnt   <= '0;
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      line_pc    <= line_nxt;
      start_pc   <= start_nxt;
      redir_pend <= pend_nxt;
      beat_cnt   <= beat_nxt;
      // The request address is frozen on entry to REQ so a redirect cannot alter it.
      if (state_nxt == REQ && state != REQ)
        req_addr <= line_nxt;
      if (redirect_valid) begin
        count <= '0;
        wptr  <= rptr;
      end else begin
        wptr  <= wptr + PTR_W'(n_push);
        rptr  <= rptr + PTR_W'(pop);
        count <= count + n_push - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int s = 0; s < IPB; s++) begin
        if (slot_keep[s]) begin
          instr_mem[slot_idx[s]] <= bus_resp[s*INSTR_WIDTH +: INSTR_WIDTH];
          pc_mem[slot_idx[s]]    <= slot_pc[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: bus model plus an expected-instruction queue,
// a table of entry-PC cases, and hand sequences for backpressure and redirects.
module tb_instr_fetch_queue;
  localparam int BB = 8;
  localparam int QD = 16;
  localparam int IPB = 2;
  localparam logic [63:0] LINE = 64'd64;
  localparam logic [12:0] TAG = 13'h1100;

  logic        clk, reset;
  logic [63:0] entry_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0] bus_req, bus_resp;
  logic [12:0] bus_reqtag, bus_resptag;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  instr_fetch_queue dut (
    .clk(clk), .reset(reset), .entry(entry_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [63:0] entry; logic [63:0] first_pc; logic [63:0] req0; logic [63:0] req1; } vec_t;

  ent_t        sbq[$];
  logic [63:0] reqs[$];
  int          n_checks = 0, n_fail = 0;
  logic        rdy = 1'b0, redir = 1'b0;
  logic [63:0] rpc = '0;
  int          ack_delay = 0, ack_wait = 0;
  logic        burst_active = 1'b0, discard = 1'b0;
  int          beat_idx = 0;
  logic [63:0] cur_burst, cur_req_addr, exp_line, exp_start;
  int          n_pops, n_beats, n_drained;
  logic        first_seen;
  logic [63:0] first_pc;

  function automatic logic [31:0] code(input logic [63:0] pc);
    return pc[31:0] ^ 32'hC3A5_0000;
  endfunction

  function automatic logic [63:0] beat_data(input logic [63:0] base, input int k);
    logic [63:0] a;
    a = base + 64'(k * 8);
    return {code(a + 64'd4), code(a)};
  endfunction

  function automatic logic [63:0] get_req(input int i);
    return (reqs.size() > i) ? reqs[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    logic reqfire, beatfire, popfire, exp_ack;
    logic [63:0] pc;
    ent_t e;
    @(negedge clk);
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    bus_reqack     = 1'b0;
    bus_respcyc    = burst_active;
    bus_resp       = burst_active ? beat_data(cur_burst, beat_idx) : '0;
    #1;
    if (bus_reqcyc && !burst_active && ack_wait == 0) bus_reqack = 1'b1;
    #1;
    chk("out_valid", out_valid, sbq.size() != 0);
    exp_ack = burst_active && (discard || (QD - sbq.size() >= IPB));
    chk("respack", bus_respack, exp_ack);
    if (bus_reqcyc) begin
      chk("bus_req", bus_req, cur_req_addr);
      chk("reqtag", bus_reqtag, TAG);
    end
    reqfire  = bus_reqcyc && bus_reqack;
    beatfire = bus_respcyc && bus_respack;
    popfire  = out_valid && out_ready && !redir;
    if (bus_reqcyc && !bus_reqack && ack_wait > 0) ack_wait--;
    if (popfire) begin
      if (sbq.size() == 0) chk("pop_nonempty", 64'd0, 64'd1);
      else begin
        e = sbq.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", out_instr, e.instr);
        if (!first_seen) begin first_seen = 1'b1; first_pc = e.pc; end
      end
      n_pops++;
    end
    if (redir) begin
      sbq.delete();
      exp_line  = {rpc[63:6], 6'd0};
      exp_start = rpc;
      discard   = 1'b1;
    end
    if (reqfire) begin
      burst_active = 1'b1;
      beat_idx     = 0;
      cur_burst    = cur_req_addr;
      ack_wait     = ack_delay;
      reqs.push_back(bus_req);
    end
    if (beatfire) begin
      if (discard) n_drained++;
      else
        for (int s = 0; s < IPB; s++) begin
          pc = cur_burst + 64'(beat_idx * 8 + s * 4);
          if (pc >= exp_start) sbq.push_back('{pc, code(pc)});
        end
      n_beats++;
      beat_idx++;
      if (beat_idx == BB) begin
        burst_active = 1'b0;
        if (!discard) begin exp_line = exp_line + LINE; exp_start = exp_line; end
        discard      = 1'b0;
        cur_req_addr = exp_line;
      end
    end
  endtask

  task automatic do_reset(input logic [63:0] e);
    @(negedge clk);
    reset = 1'b1; entry_pc = e;
    redirect_valid = 1'b0; redirect_pc = '0; bus_reqack = 1'b0;
    bus_respcyc = 1'b0; bus_resp = '0; out_ready = 1'b0;
    #1;
    chk("rst_reqcyc", bus_reqcyc, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_reqtag", bus_reqtag, 0);
    chk("rst_respack", bus_respack, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    sbq.delete(); reqs.delete();
    burst_active = 1'b0; discard = 1'b0; beat_idx = 0;
    exp_line = {e[63:6], 6'd0}; exp_start = e; cur_req_addr = exp_line;
    ack_wait = ack_delay; n_pops = 0; n_beats = 0; n_drained = 0;
    first_seen = 1'b0; first_pc = '0; redir = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_pops(input int n, input int maxc);
    int c;
    c = 0;
    while (n_pops < n && c < maxc) begin cycle(); c++; end
    chk("pop_budget", 64'(n_pops >= n), 64'd1);
  endtask

  vec_t tbl[4];

  initial begin
    reset = 1'b1; entry_pc = '0; bus_resptag = '0;
    redirect_valid = 1'b0; redirect_pc = '0; bus_reqack = 1'b0;
    bus_respcyc = 1'b0; bus_resp = '0; out_ready = 1'b0;
    tbl[0] = '{64'h1000, 64'h1000, 64'h1000, 64'h1040};
    tbl[1] = '{64'h1014, 64'h1014, 64'h1000, 64'h1040};
    tbl[2] = '{64'h103C, 64'h103C, 64'h1000, 64'h1040};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFC0, 64'hFFFF_FFFF_FFFF_FFC0, 64'hFFFF_FFFF_FFFF_FFC0, 64'h0};

    for (int i = 0; i < 4; i++) begin
      do_reset(tbl[i].entry);
      rdy = 1'b1;
      run_pops(20, 300);
      chk("first_pc", first_pc, tbl[i].first_pc);
      chk("req0", get_req(0), tbl[i].req0);
      chk("req1", get_req(1), tbl[i].req1);
    end

    // Backpressure: eight beats fill sixteen entries, the ninth is held.
    do_reset(64'h1000);
    rdy = 1'b0;
    repeat (30) cycle();
    chk("beats_when_full", 64'(n_beats), 64'd8);
    chk("valid_when_full", out_valid, 1);
    rdy = 1'b1;
    run_pops(40, 200);

    // Redirect after beat 3 of the first burst.
    do_reset(64'h1000);
    rdy = 1'b0;
    for (int c = 0; c < 50 && n_beats < 4; c++) cycle();
    chk("beats_before_redir", 64'(n_beats), 64'd4);
    rpc = 64'h2008; redir = 1'b1; first_seen = 1'b0;
    cycle();
    redir = 1'b0;
    cycle();
    chk("flush_valid", out_valid, 0);
    rdy = 1'b1;
    run_pops(6, 200);
    chk("drained_mid", 64'(n_drained), 64'd4);
    chk("redir_req", get_req(1), 64'h2000);
    chk("redir_first_pc", first_pc, 64'h2008);

    // Redirect while the request waits five cycles for its ack.
    ack_delay = 5;
    do_reset(64'h1000);
    rdy = 1'b1;
    cycle();
    chk("req_waiting", bus_reqcyc, 1);
    ack_delay = 0;
    rpc = 64'h3010; redir = 1'b1; first_seen = 1'b0;
    cycle();
    redir = 1'b0;
    run_pops(6, 200);
    chk("held_req", get_req(0), 64'h1000);
    chk("drained_full", 64'(n_drained), 64'd8);
    chk("new_req", get_req(1), 64'h3000);
    chk("new_first_pc", first_pc, 64'h3010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Parametrised instruction-fetch front end for the in-order core. Fetches instruction lines from the system bus as `BURST_BEATS`-beat read bursts and splits each beat into `BUS_DATA_WIDTH/INSTR_WIDTH` instructions. Buffers them in a `QUEUE_DEPTH`-entry FIFO that feeds decode through a valid/ready handshake. Supports redirect: queue flush, drain of in-flight beats, and restart at any instruction-aligned PC.

## Interface
- `BUS_DATA_WIDTH`, 64, bus data width in bits
- `BUS_TAG_WIDTH`, 13, bus tag width in bits
- `INSTR_WIDTH`, 32, instruction width; must divide `BUS_DATA_WIDTH`
- `BURST_BEATS`, 8, beats per line fetch; line = `BURST_BEATS*BUS_DATA_WIDTH/8` bytes (power of 2)
- `QUEUE_DEPTH`, 16, FIFO entries; power of 2, ≥ `IPB` (`IPB` = `BUS_DATA_WIDTH/INSTR_WIDTH`)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `entry`  in  64  start PC, captured while `reset`=1
- `redirect_valid`  in  1  one-cycle redirect request
- `redirect_pc`  in  64  redirect target, `INSTR_WIDTH/8`-aligned
- `bus_reqcyc`  out  1  read request valid
- `bus_req`  out  `BUS_DATA_WIDTH`  line-aligned request address
- `bus_reqtag`  out  `BUS_TAG_WIDTH`  {1'b1, `SYSBUS_MEMORY`, 8'h0}
- `bus_reqack`  in  1  request accepted
- `bus_respcyc`  in  1  response beat valid
- `bus_resp`  in  `BUS_DATA_WIDTH`  response beat
- `bus_resptag`  in  `BUS_TAG_WIDTH`  ignored
- `bus_respack`  out  1  beat consumed
- `out_valid`  out  1  head instruction valid
- `out_instr`  out  `INSTR_WIDTH`  head instruction
- `out_pc`  out  64  PC of head instruction
- `out_ready`  in  1  decode accepts head

## Operation
- Reset values: all outputs 0. Internal state: FIFO empty, `state`=IDLE, `line_pc`=`entry` & ~(LINE_BYTES-1), `start_pc`=`entry`, beat count 0.
- States:
  - IDLE → REQ after one cycle.
  - REQ: `bus_reqcyc`=1, `bus_req`=`line_pc`, tag held constant. On `bus_reqack` → RESP, or → DRAIN if a redirect is pending.
  - RESP: beats arrive in order. A beat is accepted when `bus_respcyc`=1 and free entries ≥ `IPB` (count before any same-cycle pop). On acceptance `bus_respack`=1 combinationally in that cycle; otherwise `bus_respack`=0 and the beat is held by the bus.
  - DRAIN: `bus_respack`=`bus_respcyc`; beats are discarded; after the last beat of the burst → REQ.
- Slot address = `line_pc` + beat*`BUS_DATA_WIDTH/8` + slot*`INSTR_WIDTH/8`. Slot 0 is the low bits. Slots are enqueued in ascending order; a slot is skipped if its address < `start_pc`.
- After the last beat in RESP: `line_pc` += LINE_BYTES (mod 2^64), `start_pc` = new `line_pc`, → REQ. Prefetch continues until the FIFO stalls.
- Redirect (`redirect_valid`=1, sampled at the edge):
  - FIFO flushed.
  - `line_pc` = `redirect_pc` aligned down to the line; `start_pc` = `redirect_pc`.
  - From RESP → DRAIN of the remaining beats of the current burst.
  - From REQ → `bus_reqcyc`/`bus_req` are held until ack (no cancel), then DRAIN the whole burst.
  - In DRAIN: target updated, draining continues.
  - In IDLE: target updated only.
  - Redirect has priority over a same-cycle pop or enqueue; both are dropped.
- FIFO:
  - Pop on `out_valid & out_ready`.
  - Simultaneous enqueue and pop are both performed.
  - Pointers wrap modulo `QUEUE_DEPTH`.
  - Never overflows, by the room rule above.
- `out_instr`/`out_pc` are the head entry contents; they are stable while `out_valid`=1 and `out_ready`=0.
- Async reset mid-burst: everything returns to reset values immediately. Bus recovery is the bus model's responsibility.

## Timing
- Reset deassert at edge E: REQ at E+1, `bus_reqcyc`=1 during cycle E+1.
- `bus_reqack` sampled at edge A: `bus_reqcyc`=0 from A. The first beat is accepted no earlier than cycle A+1.
- Beat accepted at edge B: entries visible and `out_valid`=1 from B, i.e. the cycle after `bus_respack` was high.
- Pop throughput: 1 instruction/cycle. Fill rate: 1 beat/cycle when room allows.
- Redirect at edge R: `out_valid`=0 from R. The first new instruction appears no earlier than (remaining beats) + 2 cycles + bus latency.

## Test plan
- Reset, `entry`=0x1000, bus returns beat k = {k*2+1, k*2}, `out_ready`=1 → 16 instructions, `out_pc` 0x1000..0x103C, then REQ of 0x1040.
- `entry`=0x1014 → first output `out_pc`=0x1014 (the instruction from slot 1 of beat 2); earlier slots are dropped.
- `out_ready`=0 with `QUEUE_DEPTH`=16 → after 8 beats the FIFO is full and the 9th beat gets no `bus_respack`. Raising `out_ready` resumes with no loss or duplication.
- Redirect to 0x2008 after beat 3 of a burst → FIFO empty next cycle, beats 4–7 acked and discarded, next `bus_req`=0x2000, first `out_pc`=0x2008.
- Redirect while `bus_reqcyc`=1 and `bus_reqack` held low 5 cycles → `bus_req` unchanged until ack, full burst drained, then REQ of the new line.
- `INSTR_WIDTH`=32, `BUS_DATA_WIDTH`=128, `BURST_BEATS`=4 → 4 instructions/beat, `line_pc` step 0x40. `line_pc`=0xFFFF_FFFF_FFFF_FFC0 wraps to 0.
